// File: rtl/sdram_ram_bridge_if.sv
// sdram_ram_bridge_if: msx_slots RAM port plus the SDRAM channel-1 request bus
interface sdram_ram_bridge_if #(parameter int AW = 27);
  logic ram_ce;
  logic ram_rnw;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic cpu_wait;
  logic sd_req;
  logic sd_rnw;
  logic [AW-1:0] sd_addr;
  logic [7:0] sd_din;
  logic [7:0] sd_dout;
  logic sd_ready;
  logic err_timeout;
  logic err_overrun;
  modport master (
    output ram_ce, ram_rnw, ram_addr, ram_din, sd_dout, sd_ready,
    input ram_dout, cpu_wait, sd_req, sd_rnw, sd_addr, sd_din, err_timeout, err_overrun
  );
  modport slave (
    input ram_ce, ram_rnw, ram_addr, ram_din, sd_dout, sd_ready,
    output ram_dout, cpu_wait, sd_req, sd_rnw, sd_addr, sd_din, err_timeout, err_overrun
  );
endinterface

// File: rtl/sdram_ram_bridge.sv
// sdram_ram_bridge: CPU RAM strobes to held SDRAM requests, posted writes, one-entry read cache
module sdram_ram_bridge #(
  parameter int DEPTH = 2,
  parameter int TIMEOUT = 255,
  parameter int AW = 27
) (
  input logic clk,
  input logic reset,
  sdram_ram_bridge_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] f_addr [DEPTH];
  logic [7:0] f_data [DEPTH];
  logic [IW:0] wp, rp;
  logic [IW-1:0] wi, ri;
  logic pw_v, rd_v, c_v;
  logic [AW-1:0] pw_addr, rd_addr, c_addr;
  logic [7:0] pw_data, c_data;
  logic [WW-1:0] wd;
  logic empty, full, busy, accept, hit, tmo, done, pop, push;
  logic [AW-1:0] push_addr;
  logic [7:0] push_data;
  assign wi = wp[IW-1:0];
  assign ri = rp[IW-1:0];
  assign empty = wp == rp;
  assign full = (wp[IW] != rp[IW]) && (wi == ri);
  assign busy = pw_v | rd_v;
  assign accept = bus.ram_ce & ~busy;
  assign hit = c_v && (bus.ram_addr == c_addr);
  assign tmo = bus.sd_req && !bus.sd_ready && (wd == WW'(TIMEOUT - 1));
  assign done = bus.sd_req & (bus.sd_ready | tmo);
  assign pop = (state == WR_ISSUE) && done;
  // a held write enters the FIFO in the same cycle the head leaves it
  assign push = (accept & ~bus.ram_rnw & ~full) | (pw_v & pop);
  assign push_addr = pw_v ? pw_addr : bus.ram_addr;
  assign push_data = pw_v ? pw_data : bus.ram_din;
  assign bus.cpu_wait = busy | (bus.ram_ce & (bus.ram_rnw ? ~hit : full));
  assign bus.sd_req = (state == WR_ISSUE) || (state == RD_ISSUE);
  assign bus.sd_rnw = state != WR_ISSUE;
  assign bus.sd_addr = (state == WR_ISSUE) ? f_addr[ri] : (state == RD_ISSUE) ? rd_addr : '0;
  assign bus.sd_din = (state == WR_ISSUE) ? f_data[ri] : '0;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = !empty ? WR_ISSUE : (rd_v || (accept && bus.ram_rnw && !hit)) ? RD_ISSUE : IDLE;
      WR_ISSUE: state_nx = done ? IDLE : WR_ISSUE;
      RD_ISSUE: state_nx = done ? RD_DONE : RD_ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) begin
      f_addr[wi] <= push_addr;
      f_data[wi] <= push_data;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      pw_v <= 1'b0;
      pw_addr <= '0;
      pw_data <= '0;
      rd_v <= 1'b0;
      rd_addr <= '0;
      c_v <= 1'b0;
      c_addr <= '0;
      c_data <= '0;
      wd <= '0;
      bus.ram_dout <= 8'hFF;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (accept && !bus.ram_rnw && full) begin
        pw_v <= 1'b1;
        pw_addr <= bus.ram_addr;
        pw_data <= bus.ram_din;
      end else if (pw_v && pop) pw_v <= 1'b0;
      if (accept && bus.ram_rnw && !hit) begin
        rd_v <= 1'b1;
        rd_addr <= bus.ram_addr;
      end else if (state == RD_ISSUE && done) rd_v <= 1'b0;
      if (accept && !bus.ram_rnw && hit) c_v <= 1'b0;
      if (accept && bus.ram_rnw && hit) bus.ram_dout <= c_data;
      else if (state == RD_ISSUE && bus.sd_ready) begin
        bus.ram_dout <= bus.sd_dout;
        c_v <= 1'b1;
        c_addr <= rd_addr;
        c_data <= bus.sd_dout;
      end else if (state == RD_ISSUE && tmo) begin
        bus.ram_dout <= 8'hFF;
        c_v <= 1'b0;
      end
      wd <= (bus.sd_req && !bus.sd_ready && !tmo) ? wd + 1'b1 : '0;
      bus.err_timeout <= bus.err_timeout | tmo;
      bus.err_overrun <= bus.err_overrun | (bus.ram_ce & busy);
    end
endmodule

// File: tb/tb_sdram_ram_bridge.sv
// tb_sdram_ram_bridge: directed steps with an SDRAM model and an in-order transaction scoreboard
module tb_sdram_ram_bridge;
  localparam int AW = 27;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  sdram_ram_bridge_if #(.AW(AW)) bus ();
  sdram_ram_bridge #(.DEPTH(2), .TIMEOUT(16), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  typedef struct packed {logic rnw; logic [AW-1:0] addr; logic [7:0] din;} txn_t;
  txn_t exp_q[$];
  logic [7:0] mem [logic [AW-1:0]];
  int total = 0, bad = 0;
  int delay = 3;
  bit hang = 1'b0;
  int wait_cnt = 0, rises = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_txn(input logic rnw, input logic [AW-1:0] a, input logic [7:0] d);
    txn_t t;
    t.rnw = rnw;
    t.addr = a;
    t.din = d;
    exp_q.push_back(t);
  endtask

  task automatic req(input logic rnw, input logic [AW-1:0] a, input logic [7:0] d, output logic w);
    bus.ram_ce = 1'b1;
    bus.ram_rnw = rnw;
    bus.ram_addr = a;
    bus.ram_din = d;
    #1 w = bus.cpu_wait;
    @(posedge clk);
    #1;
    bus.ram_ce = 1'b0;
  endtask

  task automatic wait_free(input string tag);
    for (int i = 0; i < 200 && bus.cpu_wait; i++) tick();
    chk(tag, bus.cpu_wait, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.cpu_wait || bus.sd_req); i++) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.cpu_wait) wait_cnt++;
    if (bus.sd_req && !prev_req) rises++;
    prev_req = bus.sd_req;
  end

  initial begin
    int cnt;
    txn_t t;
    cnt = 0;
    bus.sd_ready = 1'b0;
    bus.sd_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.sd_ready = 1'b0;
      if (!bus.sd_req || hang) cnt = 0;
      else if (cnt < delay - 1) cnt++;
      else begin
        cnt = 0;
        bus.sd_ready = 1'b1;
        chk("sb_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          chk("sb_rnw", bus.sd_rnw, t.rnw);
          chk("sb_addr", bus.sd_addr, t.addr);
          if (!t.rnw) begin
            chk("sb_din", bus.sd_din, t.din);
            mem[bus.sd_addr] = bus.sd_din;
          end
        end
        bus.sd_dout = !bus.sd_rnw ? 8'h00 : mem.exists(bus.sd_addr) ? mem[bus.sd_addr] : 8'h5A;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic w;
    int n, w0, r0;
    bit ok;
    bus.ram_ce = 1'b0;
    bus.ram_rnw = 1'b1;
    bus.ram_addr = '0;
    bus.ram_din = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick(3);
    reset = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ram_dout !== 8'hFF || bus.cpu_wait !== 1'b0 || bus.sd_req !== 1'b0 ||
          bus.err_timeout !== 1'b0 || bus.err_overrun !== 1'b0) ok = 1'b0;
    end
    chk("reset_quiet20", ok, 1);
    chk("reset_dout", bus.ram_dout, 8'hFF);
    chk("reset_rnw", bus.sd_rnw, 1);
    chk("reset_addr", bus.sd_addr, 0);

    delay = 3;
    w0 = wait_cnt;
    expect_txn(1'b0, 27'h00C000, 8'hA5);
    req(1'b0, 27'h00C000, 8'hA5, w);
    chk("wr_ce_wait", w, 0);
    drain("wr_drain");
    chk("wr_never_wait", wait_cnt - w0, 0);

    delay = 4;
    expect_txn(1'b0, 27'h000100, 8'h11);
    expect_txn(1'b0, 27'h000101, 8'h22);
    expect_txn(1'b0, 27'h000102, 8'h33);
    req(1'b0, 27'h000100, 8'h11, w);
    chk("wr3_a_wait", w, 0);
    req(1'b0, 27'h000101, 8'h22, w);
    chk("wr3_b_wait", w, 0);
    req(1'b0, 27'h000102, 8'h33, w);
    chk("wr3_c_wait", w, 1);
    wait_free("wr3_release");
    chk("wr3_one_popped", exp_q.size(), 2);
    drain("wr3_drain");

    delay = 2;
    mem[27'h001234] = 8'h3C;
    expect_txn(1'b1, 27'h001234, 8'h00);
    req(1'b1, 27'h001234, 8'h00, w);
    chk("rd_miss_wait", w, 1);
    chk("rd_req_latency", bus.sd_req, 1);
    wait_free("rd_miss_release");
    chk("rd_miss_data", bus.ram_dout, 8'h3C);
    chk("rd_miss_sb", exp_q.size(), 0);
    tick();
    w0 = wait_cnt;
    r0 = rises;
    req(1'b1, 27'h001234, 8'h00, w);
    chk("rd_hit_wait", w, 0);
    chk("rd_hit_data", bus.ram_dout, 8'h3C);
    tick(3);
    chk("rd_hit_no_req", rises - r0, 0);
    chk("rd_hit_no_stall", wait_cnt - w0, 0);

    expect_txn(1'b0, 27'h001234, 8'h77);
    expect_txn(1'b1, 27'h001234, 8'h00);
    req(1'b0, 27'h001234, 8'h77, w);
    chk("wri_wait", w, 0);
    req(1'b1, 27'h001234, 8'h00, w);
    chk("wri_rd_miss", w, 1);
    wait_free("wri_release");
    chk("wri_data", bus.ram_dout, 8'h77);
    drain("wri_drain");

    delay = 3;
    expect_txn(1'b1, 27'h003000, 8'h00);
    req(1'b1, 27'h003000, 8'h00, w);
    chk("ovr_first_wait", w, 1);
    chk("ovr_flag_clear", bus.err_overrun, 0);
    req(1'b0, 27'h003001, 8'h99, w);
    chk("ovr_second_wait", w, 1);
    chk("ovr_flag", bus.err_overrun, 1);
    wait_free("ovr_release");
    chk("ovr_data", bus.ram_dout, 8'h5A);
    drain("ovr_drain");
    tick(8);
    chk("ovr_ignored", mem.exists(27'h003001), 0);

    hang = 1'b1;
    req(1'b1, 27'h002000, 8'h00, w);
    chk("tmo_wait", w, 1);
    n = 0;
    for (int i = 0; i < 100 && bus.sd_req; i++) begin
      n++;
      tick();
    end
    chk("tmo_len", n, 16);
    chk("tmo_flag", bus.err_timeout, 1);
    chk("tmo_wait_rel", bus.cpu_wait, 0);
    chk("tmo_dout", bus.ram_dout, 8'hFF);

    req(1'b0, 27'h004000, 8'h99, w);
    for (int i = 0; i < 10 && !bus.sd_req; i++) tick();
    chk("rst_mid_req_up", bus.sd_req, 1);
    reset = 1'b0;
    #1;
    r0 = rises;
    chk("rst_req", bus.sd_req, 0);
    chk("rst_rnw", bus.sd_rnw, 1);
    chk("rst_addr", bus.sd_addr, 0);
    chk("rst_din", bus.sd_din, 0);
    chk("rst_wait", bus.cpu_wait, 0);
    chk("rst_dout", bus.ram_dout, 8'hFF);
    chk("rst_err_tmo", bus.err_timeout, 0);
    chk("rst_err_ovr", bus.err_overrun, 0);
    tick();
    reset = 1'b1;
    hang = 1'b0;
    tick(6);
    chk("rst_fifo_dropped", rises - r0, 0);
    chk("rst_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
